apb_cmd_master: RTL and testbench

Requester-side APB4 bridge that converts single-beat commands from a valid/ready command port into APB SETUP/ACCESS transfers, then returns read data and error status on a valid/ready response port. It sits directly upstream of the APB register slaves, drives their psel/penable/paddr/pwrite/pwdata/pstrb/pprot, and consumes pready/prdata/pslverr. It has one outstanding transfer at a time and a programmable wait-state timeout.

---
 rtl/apb_pkg.sv | 22 ++
 rtl/apb_cmd_master.sv | 143 ++++++++++++++
 tb/tb_apb_cmd_master.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_pkg.sv
// ---------------------------------------------------------------------------
// apb_pkg
// Shared APB definitions for the requester-side bridge and its users:
//   apb_state_t  - transfer FSM states (IDLE, SETUP, ACCESS, RESP)
//   PROT_*       - common pprot encodings
//   APB_AW       - APB address width
// ---------------------------------------------------------------------------
package apb_pkg;

    localparam int APB_AW = 32;

    localparam logic [2:0] PROT_NORMAL = 3'b000;
    localparam logic [2:0] PROT_PRIV   = 3'b001;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_t;

endpackage

// File: rtl/apb_cmd_master.sv
// ---------------------------------------------------------------------------
// apb_cmd_master
// Requester-side APB4 bridge. Accepts one single-beat command at a time on a
// valid/ready command port, runs it as an APB SETUP/ACCESS transfer and
// returns read data plus error/timeout status on a valid/ready response port.
//
// Ports
//   pclk, presetn          clock, asynchronous active-low reset
//   cmd_valid/cmd_ready    command handshake
//   cmd_addr/cmd_write/cmd_wdata/cmd_strb/cmd_prot   command payload
//   rsp_valid/rsp_ready    response handshake
//   rsp_rdata/rsp_err/rsp_timeout                    response payload
//   psel/penable/pwrite/paddr/pwdata/pstrb/pprot     APB requester outputs
//   pready/prdata/pslverr  APB completer inputs
//
// Every output is a register; APB inputs only reach outputs through a flop.
// ---------------------------------------------------------------------------
module apb_cmd_master
    import apb_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                      pclk,
    input  logic                      presetn,

    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [APB_AW-1:0]         cmd_addr,
    input  logic                      cmd_write,
    input  logic [DATA_WIDTH-1:0]     cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0]   cmd_strb,
    input  logic [2:0]                cmd_prot,

    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_WIDTH-1:0]     rsp_rdata,
    output logic                      rsp_err,
    output logic                      rsp_timeout,

    output logic                      psel,
    output logic                      penable,
    output logic                      pwrite,
    output logic [APB_AW-1:0]         paddr,
    output logic [DATA_WIDTH-1:0]     pwdata,
    output logic [DATA_WIDTH/8-1:0]   pstrb,
    output logic [2:0]                pprot,
    input  logic                      pready,
    input  logic [DATA_WIDTH-1:0]     prdata,
    input  logic                      pslverr
);

    // A zero timeout still needs a 1-bit counter; it then just saturates.
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT =
        (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES) : {CNT_W{1'b1}};

    apb_state_t        state;
    logic [CNT_W-1:0]  wait_cnt;
    logic              timeout_hit;

    // Abort on the ACCESS cycle whose counter already equals the limit,
    // i.e. after TIMEOUT_CYCLES+1 ACCESS cycles without pready.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (wait_cnt == CNT_LIMIT);

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            cmd_ready   <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            psel        <= 1'b0;
            penable     <= 1'b0;
            pwrite      <= 1'b0;
            paddr       <= '0;
            pwdata      <= '0;
            pstrb       <= '0;
            pprot       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        // Payload registers change only here, so they hold
                        // their last values between transfers.
                        paddr     <= cmd_addr;
                        pwrite    <= cmd_write;
                        pwdata    <= cmd_wdata;
                        pstrb     <= cmd_write ? cmd_strb : '0;
                        pprot     <= cmd_prot;
                        psel      <= 1'b1;
                        cmd_ready <= 1'b0;
                        wait_cnt  <= '0;
                        state     <= SETUP;
                    end
                end

                SETUP: begin
                    penable <= 1'b1;
                    state   <= ACCESS;
                end

                ACCESS: begin
                    if (pready) begin
                        psel        <= 1'b0;
                        penable     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_err     <= pslverr;
                        rsp_timeout <= 1'b0;
                        // Write responses and error responses carry no data.
                        rsp_rdata   <= (!pwrite && !pslverr) ? prdata : '0;
                        state       <= RESP;
                    end else if (timeout_hit) begin
                        psel        <= 1'b0;
                        penable     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_err     <= 1'b1;
                        rsp_timeout <= 1'b1;
                        rsp_rdata   <= '0;
                        state       <= RESP;
                    end else if (wait_cnt != CNT_LIMIT) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_cmd_master.sv
// ---------------------------------------------------------------------------
// tb_apb_cmd_master
// Drives apb_cmd_master against a behavioural APB register completer
// (8 word registers starting at byte address 0x8, programmable wait states)
// and compares every response, latency and APB phase count with a
// transaction-level reference model.
// ---------------------------------------------------------------------------
module tb_apb_cmd_master;
    import apb_pkg::*;

    localparam int          DW        = 32;
    localparam int          TO        = 4;
    localparam logic [31:0] BASE_ADDR = 32'h8;
    localparam int          N_REGS    = 8;
    localparam logic [31:0] END_ADDR  = 32'h28;

    logic            pclk = 1'b0;
    logic            presetn = 1'b0;
    logic            cmd_valid = 1'b0;
    logic            cmd_ready;
    logic [31:0]     cmd_addr = '0;
    logic            cmd_write = 1'b0;
    logic [DW-1:0]   cmd_wdata = '0;
    logic [DW/8-1:0] cmd_strb = '0;
    logic [2:0]      cmd_prot = '0;
    logic            rsp_valid;
    logic            rsp_ready = 1'b0;
    logic [DW-1:0]   rsp_rdata;
    logic            rsp_err;
    logic            rsp_timeout;
    logic            psel, penable, pwrite;
    logic [31:0]     paddr;
    logic [DW-1:0]   pwdata;
    logic [DW/8-1:0] pstrb;
    logic [2:0]      pprot;
    logic            pready;
    logic [DW-1:0]   prdata;
    logic            pslverr;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 pclk = ~pclk;

    apb_cmd_master #(
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .pclk        (pclk),
        .presetn     (presetn),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_addr    (cmd_addr),
        .cmd_write   (cmd_write),
        .cmd_wdata   (cmd_wdata),
        .cmd_strb    (cmd_strb),
        .cmd_prot    (cmd_prot),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .psel        (psel),
        .penable     (penable),
        .pwrite      (pwrite),
        .paddr       (paddr),
        .pwdata      (pwdata),
        .pstrb       (pstrb),
        .pprot       (pprot),
        .pready      (pready),
        .prdata      (prdata),
        .pslverr     (pslverr)
    );

    // ---------------- behavioural completer ----------------
    logic [31:0] regs [N_REGS];
    int          wait_req = 0;
    int          wcnt = 0;
    logic [31:0] c_off;
    logic        c_in;

    assign c_off   = paddr - BASE_ADDR;
    assign c_in    = (paddr >= BASE_ADDR) && (paddr < END_ADDR);
    assign pready  = psel && penable && (wcnt >= wait_req);
    assign pslverr = pready && !c_in;
    assign prdata  = c_in ? regs[c_off[4:2]] : 32'hBAD0_BAD0;

    always @(posedge pclk) begin
        if (!presetn) begin
            for (int i = 0; i < N_REGS; i++) regs[i] <= '0;
            wcnt <= 0;
        end else begin
            if (psel && penable && !pready) wcnt <= wcnt + 1;
            else                            wcnt <= 0;
            if (psel && penable && pready && pwrite && c_in)
                for (int b = 0; b < DW/8; b++)
                    if (pstrb[b]) regs[c_off[4:2]][8*b +: 8] <= pwdata[8*b +: 8];
        end
    end

    // ---------------- reference model ----------------
    logic [31:0] mdl [N_REGS];
    logic [31:0] e_addr, e_wdata, e_rdata;
    logic        e_wr, e_err, e_to;
    logic [3:0]  e_strb;
    logic [2:0]  e_prot;
    int          e_acc, e_lat;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Drive a command and work out, from the transfer rules alone, what
    // the bridge must return and how long it must take.
    task automatic start_cmd(input logic [31:0] a, input logic wr, input logic [31:0] wd,
                             input logic [3:0] st, input logic [2:0] pr, input int waits);
        logic        inr;
        logic [31:0] off;
        cmd_addr  = a;
        cmd_write = wr;
        cmd_wdata = wd;
        cmd_strb  = st;
        cmd_prot  = pr;
        cmd_valid = 1'b1;
        wait_req  = waits;

        off     = a - BASE_ADDR;
        inr     = (a >= BASE_ADDR) && (a < END_ADDR);
        e_addr  = a;
        e_wr    = wr;
        e_wdata = wd;
        e_strb  = wr ? st : 4'h0;
        e_prot  = pr;
        e_to    = (waits > TO);
        e_err   = e_to || !inr;
        e_acc   = (e_to ? TO : waits) + 1;
        e_lat   = e_acc + 2;
        e_rdata = (!wr && !e_err) ? mdl[off[4:2]] : 32'h0;
        if (wr && !e_err)
            for (int b = 0; b < 4; b++)
                if (st[b]) mdl[off[4:2]][8*b +: 8] = wd[8*b +: 8];
    endtask

    // Called at a negedge; returns at the negedge of the SETUP cycle.
    task automatic wait_accept(output int n);
        n = 0;
        while (!cmd_ready && n < 20) begin
            @(negedge pclk);
            n++;
        end
        if (!cmd_ready) check("accept_bound", 32'd0, 32'd1);
        @(posedge pclk);
        @(negedge pclk);
        cmd_valid = 1'b0;
    endtask

    // Follows the transfer from SETUP until rsp_valid.
    task automatic observe();
        int  lat, ps, pe;
        bit  seen;
        lat = 1; ps = 0; pe = 0; seen = 0;
        while (lat <= 40) begin
            if (rsp_valid) begin
                seen = 1;
                break;
            end
            if (psel) begin
                ps++;
                check("paddr", paddr, e_addr);
                check("pwrite", 32'(pwrite), 32'(e_wr));
                check("pstrb", 32'(pstrb), 32'(e_strb));
                check("pprot", 32'(pprot), 32'(e_prot));
                if (e_wr) check("pwdata", pwdata, e_wdata);
            end
            if (penable) pe++;
            check("cmd_ready_busy", 32'(cmd_ready), 32'd0);
            @(negedge pclk);
            lat++;
        end
        if (!seen) begin
            check("rsp_valid_bound", 32'd0, 32'd1);
            return;
        end
        check("latency", 32'(lat), 32'(e_lat));
        check("psel_cycles", 32'(ps), 32'(e_acc + 1));
        check("penable_cycles", 32'(pe), 32'(e_acc));
        check("rsp_rdata", rsp_rdata, e_rdata);
        check("rsp_err", 32'(rsp_err), 32'(e_err));
        check("rsp_timeout", 32'(rsp_timeout), 32'(e_to));
        check("psel_at_rsp", 32'(psel), 32'd0);
        check("penable_at_rsp", 32'(penable), 32'd0);
        check("paddr_hold", paddr, e_addr);
    endtask

    // Stalls the response, then consumes it.
    task automatic finish_rsp(input int stall);
        logic [31:0] d;
        logic        er, t;
        d = rsp_rdata; er = rsp_err; t = rsp_timeout;
        for (int i = 0; i < stall; i++) begin
            @(negedge pclk);
            check("stall_valid", 32'(rsp_valid), 32'd1);
            check("stall_rdata", rsp_rdata, d);
            check("stall_err", 32'({rsp_err, rsp_timeout}), 32'({er, t}));
            check("stall_psel", 32'(psel), 32'd0);
            check("stall_cmd_ready", 32'(cmd_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge pclk);
        rsp_ready = 1'b0;
        check("rsp_done_valid", 32'(rsp_valid), 32'd0);
        check("rsp_done_cmd_ready", 32'(cmd_ready), 32'd1);
    endtask

    task automatic run_cmd(input logic [31:0] a, input logic wr, input logic [31:0] wd,
                           input logic [3:0] st, input logic [2:0] pr, input int waits,
                           input int stall);
        int n;
        start_cmd(a, wr, wd, st, pr, waits);
        wait_accept(n);
        observe();
        finish_rsp(stall);
    endtask

    initial begin
        int n;
        for (int i = 0; i < N_REGS; i++) mdl[i] = '0;

        // reset state
        #12;
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_ctrl", 32'({psel, penable, pwrite, rsp_valid, rsp_err, rsp_timeout}), 32'd0);
        check("rst_paddr", paddr, 32'd0);
        check("rst_rdata", rsp_rdata, 32'd0);
        repeat (2) @(negedge pclk);
        presetn = 1'b1;
        @(negedge pclk);

        // write then read back, zero wait states
        run_cmd(32'h10, 1'b1, 32'hDEAD_BEEF, 4'hF, PROT_NORMAL, 0, 0);
        run_cmd(32'h10, 1'b0, 32'h0, 4'hF, PROT_PRIV, 0, 0);

        // out-of-range read
        run_cmd(32'h40, 1'b0, 32'h0, 4'h0, PROT_NORMAL, 0, 1);

        // wait-stated read returning 0x1234
        run_cmd(32'h14, 1'b1, 32'h0000_1234, 4'hF, PROT_NORMAL, 1, 0);
        run_cmd(32'h14, 1'b0, 32'h0, 4'h0, PROT_NORMAL, 3, 0);

        // timeout: completer never ready
        run_cmd(32'h18, 1'b0, 32'h0, 4'h0, PROT_NORMAL, 1000, 0);

        // backpressure with the next command already waiting
        start_cmd(32'h1C, 1'b1, 32'hA5A5_5A5A, 4'h5, 3'b010, 0);
        wait_accept(n);
        observe();
        start_cmd(32'h1C, 1'b0, 32'h0, 4'h0, 3'b110, 0);
        finish_rsp(6);
        wait_accept(n);
        check("backpressure_accept_gap", 32'(n), 32'd0);
        observe();
        finish_rsp(0);

        // randomized traffic
        for (int k = 0; k < 40; k++) begin
            int          sel;
            logic [31:0] a;
            sel = int'($urandom_range(0, 9));
            if (sel < 8)       a = BASE_ADDR + 32'(4 * sel);
            else if (sel == 8) a = 32'h4;
            else               a = 32'h40 + 32'(4 * $urandom_range(0, 15));
            run_cmd(a, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)),
                    3'($urandom_range(0, 7)), int'($urandom_range(0, 6)),
                    int'($urandom_range(0, 3)));
        end

        // reset in the middle of ACCESS
        start_cmd(32'h10, 1'b0, 32'h0, 4'h0, PROT_NORMAL, 3);
        wait_accept(n);
        @(negedge pclk);
        check("pre_rst_penable", 32'(penable), 32'd1);
        #2 presetn = 1'b0;
        #1;
        check("mid_rst_psel", 32'(psel), 32'd0);
        check("mid_rst_penable", 32'(penable), 32'd0);
        check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        @(negedge pclk);
        presetn = 1'b1;
        for (int i = 0; i < N_REGS; i++) mdl[i] = '0;
        @(negedge pclk);
        check("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("post_rst_psel", 32'(psel), 32'd0);

        // traffic resumes after reset
        run_cmd(32'h20, 1'b1, 32'h0BAD_F00D, 4'hC, PROT_PRIV, 2, 0);
        run_cmd(32'h20, 1'b0, 32'h0, 4'h0, PROT_PRIV, 0, 0);
        run_cmd(32'h10, 1'b0, 32'h0, 4'h0, PROT_NORMAL, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
